// File: rtl/nbit_adder.sv
// N-bit adder with carry-in/out, signed overflow and a registered copy of the result.
// Define NBIT_ADDER_CLA_EN for a two-level 4-bit-group carry-lookahead network (default: ripple).
module nbit_adder #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         cin,
  output logic [N-1:0] SUM,
  output logic         cout,
  output logic         ovf,
  output logic [N-1:0] sum_q,
  output logic         cout_q,
  output logic         ovf_q
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = A & B;
  assign p = A ^ B;

`ifdef NBIT_ADDER_CLA_EN
  localparam int unsigned NumGroups = (N + 3) / 4;

  logic [NumGroups-1:0] grp_g;
  logic [NumGroups-1:0] grp_p;
  logic [NumGroups:0]   grp_c;

  always_comb begin
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;
    c     = '0;

    // Group generate/propagate; the last group may hold fewer than 4 bits.
    for (int j = 0; j < int'(NumGroups); j++) begin
      logic gen_acc;
      logic prop_acc;
      gen_acc  = 1'b0;
      prop_acc = 1'b1;
      for (int b = 0; b < 4; b++) begin
        if (4 * j + b < int'(N)) begin
          gen_acc  = g[4*j+b] | (p[4*j+b] & gen_acc);
          prop_acc = prop_acc & p[4*j+b];
        end
      end
      grp_g[j] = gen_acc;
      grp_p[j] = prop_acc;
    end

    // Second level: each group carry is a flat sum of products over lower groups.
    grp_c[0] = cin;
    for (int j = 0; j < int'(NumGroups); j++) begin
      logic term;
      logic prod;
      term = 1'b0;
      prod = 1'b1;
      for (int k = j; k >= 0; k--) begin
        term = term | (grp_g[k] & prod);
        prod = prod & grp_p[k];
      end
      grp_c[j+1] = term | (cin & prod);
    end

    // Bit carries inside each group, seeded from the group carry-in.
    c[0] = cin;
    for (int i = 0; i < int'(N); i++) begin
      logic term;
      logic prod;
      int   base;
      base = (i / 4) * 4;
      term = 1'b0;
      prod = 1'b1;
      for (int k = i; k >= base; k--) begin
        term = term | (g[k] & prod);
        prod = prod & p[k];
      end
      c[i+1] = term | (grp_c[i/4] & prod);
    end
  end
`else
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < int'(N); i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end
`endif

  assign SUM  = p ^ c[N-1:0];
  assign cout = c[N];
  assign ovf  = c[N-1] ^ c[N];

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sum_q  <= SUM;
      cout_q <= cout;
      ovf_q  <= ovf;
    end
  end

endmodule

// File: tb/tb_nbit_adder.sv
// Self-checking bench for nbit_adder (N = 8): directed cases, reset behaviour and a random sweep,
// with registered results checked through an expected-value queue.
module tb_nbit_adder;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         cin;
  logic [N-1:0] SUM;
  logic         cout;
  logic         ovf;
  logic [N-1:0] sum_q;
  logic         cout_q;
  logic         ovf_q;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Expected registered result: {ovf, cout, sum}.
  logic [N+1:0] exp_q[$];

  always #5 clk = ~clk;

  nbit_adder #(.N(N)) dut (
    .clk    (clk),
    .reset  (reset),
    .A      (A),
    .B      (B),
    .cin    (cin),
    .SUM    (SUM),
    .cout   (cout),
    .ovf    (ovf),
    .sum_q  (sum_q),
    .cout_q (cout_q),
    .ovf_q  (ovf_q)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive after the falling edge, check combinational outputs, then check the register.
  task automatic step(input logic [N-1:0] a, input logic [N-1:0] b, input logic ci,
                      input logic rst_n);
    logic [N:0]   full;
    logic [N-1:0] es;
    logic         ec;
    logic         eo;
    logic [N+1:0] exp_reg;
    @(negedge clk);
    A     = a;
    B     = b;
    cin   = ci;
    reset = rst_n;
    #1;
    full = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    es   = full[N-1:0];
    ec   = full[N];
    eo   = (a[N-1] == b[N-1]) && (es[N-1] != a[N-1]);
    check("sum", {8'h0, SUM}, {8'h0, es});
    check("cout", {15'h0, cout}, {15'h0, ec});
    check("ovf", {15'h0, ovf}, {15'h0, eo});
    exp_q.push_back(rst_n ? {eo, ec, es} : '0);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL queue: got empty, expected entry");
    end else begin
      exp_reg = exp_q.pop_front();
      check("sum_q", {8'h0, sum_q}, {8'h0, exp_reg[N-1:0]});
      check("cout_q", {15'h0, cout_q}, {15'h0, exp_reg[N]});
      check("ovf_q", {15'h0, ovf_q}, {15'h0, exp_reg[N+1]});
    end
  endtask

  initial begin
    reset = 1'b0;
    A     = '0;
    B     = '0;
    cin   = 1'b0;

    step(8'h00, 8'h00, 1'b0, 1'b0);
    check("rst_sum_q", {8'h0, sum_q}, 16'h0000);
    step(8'h00, 8'h00, 1'b0, 1'b1);
    check("zero_sum", {8'h0, SUM}, 16'h0000);
    check("zero_cout", {15'h0, cout}, 16'h0000);

    step(8'h0F, 8'h01, 1'b0, 1'b1);
    check("tp1_sum", {8'h0, SUM}, 16'h0010);
    check("tp1_sum_q", {8'h0, sum_q}, 16'h0010);
    step(8'hFF, 8'hFF, 1'b1, 1'b1);
    check("ones_sum", {8'h0, SUM}, 16'h00FF);
    check("ones_cout", {15'h0, cout}, 16'h0001);
    check("ones_ovf", {15'h0, ovf}, 16'h0000);
    step(8'h7F, 8'h01, 1'b0, 1'b1);
    check("povf_sum", {8'h0, SUM}, 16'h0080);
    check("povf_ovf", {15'h0, ovf}, 16'h0001);
    step(8'h80, 8'h80, 1'b0, 1'b1);
    check("novf_sum", {8'h0, SUM}, 16'h0000);
    check("novf_cout", {15'h0, cout}, 16'h0001);
    check("novf_ovf", {15'h0, ovf}, 16'h0001);

    // Reset held with live operands.
    for (int i = 0; i < 3; i++) begin
      step(8'hAA, 8'h55, 1'b1, 1'b0);
      check("hold_sum_q", {8'h0, sum_q}, 16'h0000);
      check("hold_cout_q", {15'h0, cout_q}, 16'h0000);
    end
    check("hold_sum", {8'h0, SUM}, 16'h0000);
    check("hold_cout", {15'h0, cout}, 16'h0001);
    step(8'hAA, 8'h55, 1'b1, 1'b1);
    check("rel_sum_q", {8'h0, sum_q}, 16'h0000);
    check("rel_cout_q", {15'h0, cout_q}, 16'h0001);

    // Single-cycle reset pulse mid-stream.
    step(8'h12, 8'h34, 1'b0, 1'b1);
    step(8'h21, 8'h43, 1'b1, 1'b0);
    check("pulse_sum_q", {8'h0, sum_q}, 16'h0000);
    step(8'h21, 8'h43, 1'b1, 1'b1);
    check("resume_sum_q", {8'h0, sum_q}, 16'h0065);

    for (int i = 0; i < 10000; i++) begin
      step(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 99) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/nbit_adder.md
# nbit_adder

Parameterised N-bit binary adder with carry-in and carry-out. It is used as a leaf arithmetic cell in the MAC datapath. The primary SUM/cout path is purely combinational. A registered copy of the result is provided for pipelined consumers and is the only state in the block.

## Interface
- N, default 8: operand and sum width in bits; legal range 1 to 64.
- clk  input  1  rising-edge clock; used only by the result register.
- reset  input  1  synchronous, active-low reset (reset = 0 clears the registers).
- A  input  N  operand A, unsigned or two's complement.
- B  input  N  operand B, unsigned or two's complement.
- cin  input  1  carry-in, weight 1.
- SUM  output  N  combinational sum, bits [N-1:0] of A + B + cin.
- cout  output  1  combinational carry-out, bit N of A + B + cin.
- ovf  output  1  combinational signed overflow: carry into bit N-1 XOR cout.
- sum_q  output  N  SUM registered on the rising edge of clk.
- cout_q  output  1  cout registered on the rising edge of clk.
- ovf_q  output  1  ovf registered on the rising edge of clk.

## Operation
- {cout, SUM} = A + B + cin, computed exactly at N+1 bits. No truncation other than the split into SUM and cout.
- Structure: a full-adder cell per bit (g = a&b, p = a^b, s = p^c) plus a carry network. The ripple or lookahead choice is made under Configuration.
- ovf = c[N-1] ^ cout, where c[i] is the carry into bit i. For N = 1, c[0] = cin.
- SUM, cout and ovf depend only on A, B and cin. They are independent of clk and reset, including while reset is asserted.
- Result register:
  - On each rising edge with reset = 1: sum_q <= SUM, cout_q <= cout, ovf_q <= ovf.
  - On a rising edge with reset = 0: sum_q, cout_q and ovf_q are all cleared to 0.
- There is no state machine, no handshake and no enable. The register loads every cycle.
- Boundary cases:
  - All-ones + all-ones + 1 gives SUM = all-ones, cout = 1.
  - All-zeros + all-zeros + 0 gives all outputs 0.
  - X or Z on inputs propagates; no masking is required.

## Timing
- Combinational path: zero-cycle latency. SUM, cout and ovf settle within the same cycle as any input change.
- Registered path: one-cycle latency. The sum_q value visible after edge k equals the SUM present just before edge k.
- Reset values: sum_q = 0, cout_q = 0, ovf_q = 0 from the first edge sampled with reset = 0 until the first edge with reset = 1.
- Reset de-assertion: the first edge with reset = 1 captures the operands present at that edge.
- Reset asserted mid-stream: the register clears at the next edge. The combinational outputs keep tracking the inputs.
- Critical path, ripple form: N full-adder carry stages.

## Configuration
- NBIT_ADDER_CLA_EN defined:
  - The carry network is a carry-lookahead built from 4-bit groups with group generate/propagate, and a second-level lookahead across groups.
  - A final partial group handles N not divisible by 4.
- NBIT_ADDER_CLA_EN undefined: the carry network is a plain ripple chain, c[i+1] = g[i] | (p[i] & c[i]).
- Both forms are bit-exact identical on SUM, cout and ovf for all inputs. Only area and timing differ.

## Test plan
All scenarios use N = 8; build and run every scenario both with and without NBIT_ADDER_CLA_EN.
- A = 0x0F, B = 0x01, cin = 0 -> SUM = 0x10, cout = 0, ovf = 0. After one edge with reset = 1, sum_q = 0x10.
- A = 0xFF, B = 0xFF, cin = 1 -> SUM = 0xFF, cout = 1, ovf = 0.
- A = 0x7F, B = 0x01, cin = 0 -> SUM = 0x80, cout = 0, ovf = 1. Also A = 0x80, B = 0x80, cin = 0 -> SUM = 0x00, cout = 1, ovf = 1.
- Hold reset = 0 with A = 0xAA, B = 0x55, cin = 1:
  - SUM = 0x00 and cout = 1 combinationally.
  - sum_q, cout_q and ovf_q stay 0 at every edge.
  - The first edge after reset = 1 gives sum_q = 0x00, cout_q = 1.
- Assert reset = 0 for one edge mid-stream -> the registers are 0 for exactly that cycle and resume with the current operands on the next edge.
- Randomised sweep, at least 10 000 cycles, random A, B, cin -> {cout, SUM} equals A + B + cin every cycle, and sum_q/cout_q equal the previous cycle's expected values.
